// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu / DMA memory arbiter: default bus widths,
// read-owner encodings, requester IDs and the arbitration counter width.
package cpu_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  // Width of the starvation and burst counters (limits range 1-15).
  localparam int CNT_W = 4;

  // Who issued the read whose data appears on mem_rdata this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_CPU  = 2'b01,
    RD_DMA  = 2'b10
  } rd_owner_e;

  // Requester IDs as seen by the grant logic.
  localparam logic REQ_ID_CPU = 1'b0;
  localparam logic REQ_ID_DMA = 1'b1;

  // Convert an integer parameter into a counter-width limit value.
  function automatic logic [CNT_W-1:0] cnt_limit(input int value);
    return CNT_W'(value);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Small saturating up-counter with synchronous clear, used by the arbiter
// for both the cpu-streak (starvation) and DMA-streak (burst) counts.
module arb_sat_counter
  import cpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt_q
);

  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// The cpu normally wins; a starvation counter forces the DMA engine in after
// STARVE_MAX consecutive cpu grants, and a burst counter hands the bus back
// to the cpu after DMA_BURST consecutive forced DMA grants.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4,
  parameter int DMA_BURST  = 2
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] STARVE_LIM = cnt_limit(STARVE_MAX);
  localparam logic [CNT_W-1:0] BURST_LIM  = cnt_limit(DMA_BURST);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] burst_cnt_q;
  rd_owner_e        rd_owner_q;
  rd_owner_e        rd_owner_d;

  logic force_dma;
  logic dma_win;
  logic cpu_win;
  logic winner_id;

  // Grant decision. A forced DMA turn starts when the cpu has starved the DMA
  // engine for STARVE_MAX grants and carries on while the burst is still
  // below DMA_BURST, so the DMA engine gets a real burst even though its
  // first grant clears the starvation count. Nothing is granted in reset.
  always_comb begin
    force_dma = ((starve_cnt_q == STARVE_LIM) || (burst_cnt_q != '0)) &&
                (burst_cnt_q < BURST_LIM);
    dma_win   = !R && dma_req && (!cpu_req || force_dma);
    cpu_win   = !R && cpu_req && !dma_win;
    winner_id = dma_win ? REQ_ID_DMA : REQ_ID_CPU;
  end

  // Memory port mux and requester handshakes. The cpu side owns the address
  // bus whenever the DMA engine is not granted; its write strobe is only
  // passed through on a real cpu grant.
  always_comb begin
    dma_gnt   = dma_win;
    cpu_rdy   = !dma_win;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_win && cpu_we;
    if (winner_id == REQ_ID_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
    cpu_rdata  = mem_rdata;
    dma_rdata  = mem_rdata;
    dma_rvalid = !R && (rd_owner_q == RD_DMA);
  end

  // Tag the read issued this cycle so the returning data can be steered.
  always_comb begin
    rd_owner_d = RD_NONE;
    if (dma_win && !dma_we) begin
      rd_owner_d = RD_DMA;
    end else if (cpu_win && !cpu_we) begin
      rd_owner_d = RD_CPU;
    end
  end

  // Read-owner register; reset drops any read still in flight.
  always_ff @(posedge CLK) begin
    if (R) begin
      rd_owner_q <= RD_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Consecutive cpu grants while the DMA engine is waiting.
  arb_sat_counter #(
    .W(CNT_W)
  ) u_starve_cnt (
    .clk  (CLK),
    .rst  (R),
    .clr  (dma_win || !dma_req),
    .inc  (cpu_win && dma_req),
    .limit(STARVE_LIM),
    .cnt_q(starve_cnt_q)
  );

  // Consecutive DMA grants while the cpu is waiting.
  arb_sat_counter #(
    .W(CNT_W)
  ) u_burst_cnt (
    .clk  (CLK),
    .rst  (R),
    .clr  (cpu_win || !cpu_req),
    .inc  (dma_win && cpu_req),
    .limit(BURST_LIM),
    .cnt_q(burst_cnt_q)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a table of hand-derived cycle vectors for the
// directed scenarios, then randomized traffic checked against a reference
// model of the arbitration rules with a shadow copy of memory.
module tb_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SM = 4;
  localparam int DB = 2;

  logic          CLK = 1'b0;
  logic          R;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_rdy, dma_gnt, dma_rvalid, mem_we;

  always #5 CLK = ~CLK;

  bus_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .DMA_BURST(DB)) dut (
    .CLK(CLK), .R(R),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(input logic [12:0] a);
    if (a == 13'h0200) return 8'h5A;
    if (a == 13'h1000) return 8'h3C;
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  // Single-port synchronous memory, 1-cycle read latency, preloaded on the first edge.
  logic [7:0] mem [0:8191];
  logic       mem_init_done = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_val(13'(i));
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[12:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[12:0]];
  end

  typedef struct {
    logic        r, creq, cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        dreq, dwe;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic        tab;
    logic        e_gnt, e_rdy, e_we, e_rv, e_rchk;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tab[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_starve = 0;   // cpu grants in a row while DMA waited
  int         m_burst  = 0;   // DMA grants in a row while cpu waited
  int         m_owner  = 0;   // 0 none, 1 cpu, 2 dma: read issued last cycle
  logic [7:0] m_rd_val = '0;
  bit         m_dma_win = 0;
  logic [7:0] shadow [0:8191];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic creq, input logic cwe, input logic [15:0] caddr,
                     input logic [7:0] cwd, input logic dreq, input logic dwe,
                     input logic [15:0] daddr, input logic [7:0] dwd, input logic gnt,
                     input logic we, input logic rv, input logic rchk, input logic [7:0] rd);
    vec_t v;
    v.r = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.tab = 1'b1;
    v.e_gnt = gnt; v.e_rdy = !gnt; v.e_we = we; v.e_rv = rv; v.e_rchk = rchk; v.e_rd = rd;
    tab.push_back(v);
  endtask

  // Shorthand: cpu reads 0x0200, DMA reads 0x1000.
  task automatic ab(input logic r, input logic creq, input logic dreq, input logic gnt,
                    input logic rv, input logic rchk, input logic [7:0] rd);
    add(r, creq, 1'b0, 16'h0200, 8'h00, dreq, 1'b0, 16'h1000, 8'h00, gnt, 1'b0, rv, rchk, rd);
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input vec_t v);
    bit forced, dw, cw, ewe;
    logic [15:0] ea;
    logic [7:0]  ewd;
    R = v.r;
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
    #4;
    // DMA is owed a turn after SM starving cpu grants, and keeps it for up to DB beats.
    forced = ((m_starve >= SM) || (m_burst > 0)) && (m_burst < DB);
    dw  = !v.r && v.dreq && (!v.creq || forced);
    cw  = !v.r && v.creq && !dw;
    ea  = dw ? v.daddr : v.caddr;
    ewd = dw ? v.dwd : v.cwd;
    ewe = dw ? v.dwe : (cw && v.cwe);
    check("dma_gnt", 32'(dma_gnt), 32'(dw));
    check("cpu_rdy", 32'(cpu_rdy), 32'(!dw));
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    if (ewe) check("mem_wdata", 32'(mem_wdata), 32'(ewd));
    check("dma_rvalid", 32'(dma_rvalid), 32'(!v.r && (m_owner == 2)));
    if (!v.r && (m_owner == 2)) check("dma_rdata", 32'(dma_rdata), 32'(m_rd_val));
    if (m_owner == 1) check("cpu_rdata", 32'(cpu_rdata), 32'(m_rd_val));
    if (v.tab) begin
      check("tab_dma_gnt", 32'(dma_gnt), 32'(v.e_gnt));
      check("tab_cpu_rdy", 32'(cpu_rdy), 32'(v.e_rdy));
      check("tab_mem_we", 32'(mem_we), 32'(v.e_we));
      check("tab_dma_rvalid", 32'(dma_rvalid), 32'(v.e_rv));
      if (v.e_rchk) begin
        check("tab_cpu_rdata", 32'(cpu_rdata), 32'(v.e_rd));
        check("tab_dma_rdata", 32'(dma_rdata), 32'(v.e_rd));
      end
    end
    m_dma_win = dw;
    @(posedge CLK);
    if (v.r) begin
      m_starve = 0; m_burst = 0; m_owner = 0;
    end else begin
      if (dw || !v.dreq) m_starve = 0;
      else if (cw && (m_starve < SM)) m_starve++;
      if (cw || !v.creq) m_burst = 0;
      else if (dw && (m_burst < DB)) m_burst++;
      m_owner = (dw && !v.dwe) ? 2 : ((cw && !v.cwe) ? 1 : 0);
      if (m_owner != 0) m_rd_val = shadow[ea[12:0]];
      if (ewe) shadow[ea[12:0]] = ewd;
    end
    #1;
  endtask

  initial begin
    vec_t v, pv;
    for (int i = 0; i < 8192; i++) shadow[i] = init_val(13'(i));

    // cpu alone reading 0x0200 (two reset cycles first so memory is preloaded)
    ab(1, 1, 0, 0, 0, 0, 8'h00);
    ab(1, 1, 0, 0, 0, 0, 8'h00);
    ab(0, 1, 0, 0, 0, 1, 8'h5A);
    ab(0, 1, 0, 0, 0, 1, 8'h5A);
    ab(0, 1, 0, 0, 0, 1, 8'h5A);
    // both requesting: cpu x4, DMA x2, cpu
    ab(0, 1, 1, 0, 0, 1, 8'h5A);
    ab(0, 1, 1, 0, 0, 1, 8'h5A);
    ab(0, 1, 1, 0, 0, 1, 8'h5A);
    ab(0, 1, 1, 0, 0, 1, 8'h5A);
    ab(0, 1, 1, 1, 0, 1, 8'h5A);
    ab(0, 1, 1, 1, 1, 1, 8'h3C);
    ab(0, 1, 1, 0, 1, 1, 8'h3C);
    ab(0, 1, 1, 0, 0, 1, 8'h5A);
    ab(0, 1, 0, 0, 0, 1, 8'h5A);
    // DMA writes 0xA5 to 0x0300 three times, cpu reads it back
    add(0, 0, 0, 16'h0300, 8'h00, 1, 1, 16'h0300, 8'hA5, 1, 1, 0, 1, 8'h5A);
    add(0, 0, 0, 16'h0300, 8'h00, 1, 1, 16'h0300, 8'hA5, 1, 1, 0, 0, 8'h00);
    add(0, 0, 0, 16'h0300, 8'h00, 1, 1, 16'h0300, 8'hA5, 1, 1, 0, 0, 8'h00);
    add(0, 1, 0, 16'h0300, 8'h00, 0, 0, 16'h0300, 8'h00, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 16'h0300, 8'h00, 0, 0, 16'h0300, 8'h00, 0, 0, 0, 1, 8'hA5);
    // reset clears the starvation count; reset right after a DMA read drops rvalid
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(1, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 1, 1, 8'h3C);
    ab(1, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 1, 1, 8'h3C);
    ab(0, 1, 1, 0, 1, 1, 8'h3C);
    // dma_req drops at starve 3: count restarts, DMA only after 4 more cpu cycles
    ab(0, 0, 0, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 0, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 0, 0, 8'h00);
    ab(0, 1, 1, 1, 1, 1, 8'h3C);
    ab(0, 1, 1, 0, 1, 1, 8'h3C);
    // starve limit reached as cpu_req drops: one normal DMA grant, no extra beat
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 0, 0, 8'h00);
    ab(0, 0, 1, 1, 0, 0, 8'h00);
    ab(0, 1, 1, 0, 1, 1, 8'h3C);

    foreach (tab[i]) step(tab[i]);

    // Randomized traffic; an ungranted requester holds its request and inputs.
    pv = tab[tab.size()-1];
    for (int n = 0; n < 3000; n++) begin
      v = pv;
      v.tab = 1'b0;
      v.r   = ($urandom_range(0, 63) == 0);
      if (!(pv.creq && m_dma_win)) begin
        v.creq  = ($urandom_range(0, 9) < 7);
        v.cwe   = ($urandom_range(0, 2) == 0);
        v.caddr = 16'h0300 + 16'($urandom_range(0, 7));
        v.cwd   = 8'($urandom);
      end
      if (!(pv.dreq && !m_dma_win)) begin
        v.dreq  = ($urandom_range(0, 9) < 6);
        v.dwe   = ($urandom_range(0, 2) == 0);
        v.daddr = 16'h0300 + 16'($urandom_range(0, 7));
        v.dwd   = 8'($urandom);
      end
      step(v);
      pv = v;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
